// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Cathode patterns are active low, ordered {ca,cb,cc,cd,ce,cf,cg}.
package seg_pkg;

    // All segments off
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Level of an inactive (dark) anode line
    localparam logic AN_OFF = 1'b1;

    // Hex digit to cathode pattern, index 0..F
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,
        7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60,
        7'h31, 7'h42, 7'h30, 7'h38
    };

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex digit to active-low 7-segment cathode decoder.
module seg7_hex_dec
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_HEX[hex_i];

endmodule

// File: rtl/seg_display_scan_n.sv
// Multiplexed N-digit 7-segment scanner with per-digit enable, PWM brightness
// and frame-synchronous (tear-free) data update through a pending shadow.
// Optional feature: define SEG_LZ_BLANK_EN for leading-zero blanking.
module seg_display_scan_n
    import seg_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 8,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BRIGHT_W    = 4
) (
    input  logic                    ck,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   digits,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic                    load,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic                    busy,
    output logic                    frame_done,
    output logic [N_DIGITS-1:0]     an,
    output logic [6:0]              c,
    output logic                    dp_n
);

    localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
    localparam int unsigned SEL_W = $clog2(N_DIGITS);

    logic [PRE_W-1:0]        prescaler_q, prescaler_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [BRIGHT_W-1:0]     pwm_q, pwm_d;
    logic                    tick, last_sel, boundary;

    logic [4*N_DIGITS-1:0]   pend_digits_q, pend_digits_d;
    logic [N_DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic [N_DIGITS-1:0]     pend_en_q, pend_en_d;
    logic [4*N_DIGITS-1:0]   act_digits_q, act_digits_d;
    logic [N_DIGITS-1:0]     act_dp_q, act_dp_d;
    logic [N_DIGITS-1:0]     act_en_q, act_en_d;
    logic                    busy_q, busy_d;
    logic                    frame_done_q;

    logic [N_DIGITS-1:0]     eff_en;
    logic [3:0]              cur_digit;
    logic                    cur_dp, cur_en, lit;
    logic [6:0]              cur_seg;
    logic [N_DIGITS-1:0]     an_q, an_d;
    logic [6:0]              c_q, c_d;
    logic                    dp_n_q, dp_n_d;

    // Slot timing: prescaler tick advances the digit select; the last slot's tick ends a frame
    always_comb begin
        tick        = (prescaler_q == PRE_W'(REFRESH_DIV - 1));
        last_sel    = (sel_q == SEL_W'(N_DIGITS - 1));
        boundary    = tick & last_sel;
        prescaler_d = tick ? '0 : prescaler_q + PRE_W'(1);
        sel_d       = sel_q;
        if (tick) begin
            sel_d = last_sel ? '0 : sel_q + SEL_W'(1);
        end
        pwm_d = pwm_q + BRIGHT_W'(1);
    end

    // Shadow/active update: a load on the boundary bypasses the shadow entirely
    always_comb begin
        pend_digits_d = pend_digits_q;
        pend_dp_d     = pend_dp_q;
        pend_en_d     = pend_en_q;
        act_digits_d  = act_digits_q;
        act_dp_d      = act_dp_q;
        act_en_d      = act_en_q;
        busy_d        = busy_q;
        if (load && boundary) begin
            act_digits_d = digits;
            act_dp_d     = dp;
            act_en_d     = digit_en;
            busy_d       = 1'b0;
        end else if (load) begin
            pend_digits_d = digits;
            pend_dp_d     = dp;
            pend_en_d     = digit_en;
            busy_d        = 1'b1;
        end else if (boundary && busy_q) begin
            act_digits_d = pend_digits_q;
            act_dp_d     = pend_dp_q;
            act_en_d     = pend_en_q;
            busy_d       = 1'b0;
        end
    end

`ifdef SEG_LZ_BLANK_EN
    logic [N_DIGITS-1:0] lz_mask_q, lz_mask_d;

    // Dark digits from the top down while they hold 0 with no dp; digit 0 always shown
    function automatic logic [N_DIGITS-1:0] lz_mask_f(input logic [4*N_DIGITS-1:0] d,
                                                      input logic [N_DIGITS-1:0]   p);
        logic [N_DIGITS-1:0] mask;
        logic                run;
        mask = '0;
        run  = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if (run && (d[4*i +: 4] == 4'h0) && !p[i]) begin
                mask[i] = 1'b1;
            end else begin
                run = 1'b0;
            end
        end
        return mask;
    endfunction

    // Mask tracks the next active data so it switches in the same cycle as the data
    always_comb begin
        lz_mask_d = lz_mask_f(act_digits_d, act_dp_d);
    end

    // Leading-zero mask register
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            lz_mask_q <= '0;
        end else begin
            lz_mask_q <= lz_mask_d;
        end
    end

    assign eff_en = act_en_q & ~lz_mask_q;
`else
    assign eff_en = act_en_q;
`endif

    // Select the active digit under scan
    always_comb begin
        cur_digit = 4'h0;
        cur_dp    = 1'b0;
        cur_en    = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                cur_digit = act_digits_q[4*i +: 4];
                cur_dp    = act_dp_q[i];
                cur_en    = eff_en[i];
            end
        end
        lit = (brightness == '1) | (pwm_q < brightness);
    end

    seg7_hex_dec u_hex_dec (
        .hex_i (cur_digit),
        .seg_o (cur_seg)
    );

    // Pin-level next values: blank unless the selected digit is enabled and in its PWM on-phase
    always_comb begin
        an_d   = {N_DIGITS{AN_OFF}};
        c_d    = SEG_BLANK;
        dp_n_d = 1'b1;
        if (lit && cur_en) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (sel_q == SEL_W'(i)) begin
                    an_d[i] = ~AN_OFF;
                end
            end
            c_d    = cur_seg;
            dp_n_d = ~cur_dp;
        end
    end

    // State and output registers
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q   <= '0;
            sel_q         <= '0;
            pwm_q         <= '0;
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_en_q     <= '0;
            act_digits_q  <= '0;
            act_dp_q      <= '0;
            act_en_q      <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            an_q          <= {N_DIGITS{AN_OFF}};
            c_q           <= SEG_BLANK;
            dp_n_q        <= 1'b1;
        end else begin
            prescaler_q   <= prescaler_d;
            sel_q         <= sel_d;
            pwm_q         <= pwm_d;
            pend_digits_q <= pend_digits_d;
            pend_dp_q     <= pend_dp_d;
            pend_en_q     <= pend_en_d;
            act_digits_q  <= act_digits_d;
            act_dp_q      <= act_dp_d;
            act_en_q      <= act_en_d;
            busy_q        <= busy_d;
            frame_done_q  <= boundary;
            an_q          <= an_d;
            c_q           <= c_d;
            dp_n_q        <= dp_n_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign an         = an_q;
    assign c          = c_q;
    assign dp_n       = dp_n_q;

endmodule

// File: tb/tb_seg_display_scan_n.sv
// Self-checking bench for seg_display_scan_n (3 digits, 4-cycle slots, 2-bit PWM).
module tb_seg_display_scan_n;

    localparam int N  = 3;
    localparam int RD = 4;
    localparam int BW = 2;
    localparam int FRAME = N * RD;

    logic            ck;
    logic            rst_n;
    logic [4*N-1:0]  dig;
    logic [N-1:0]    dpi;
    logic [N-1:0]    en;
    logic            ld;
    logic [BW-1:0]   br;
    logic            busy, frame_done, dp_n;
    logic [N-1:0]    an;
    logic [6:0]      c;

    seg_display_scan_n #(
        .N_DIGITS    (N),
        .REFRESH_DIV (RD),
        .BRIGHT_W    (BW)
    ) dut (
        .ck         (ck),
        .rst_n      (rst_n),
        .digits     (dig),
        .dp         (dpi),
        .digit_en   (en),
        .load       (ld),
        .brightness (br),
        .busy       (busy),
        .frame_done (frame_done),
        .an         (an),
        .c          (c),
        .dp_n       (dp_n)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Lit segments per hex value, {a,b,c,d,e,f,g}, 1 = segment on
    logic [6:0] seg_on [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    int checks = 0;
    int errors = 0;

    // Reference model: what is shown, what is queued, cycles since reset
    int           m_cyc;
    logic [4*N-1:0] m_dig, p_dig;
    logic [N-1:0] m_dp, p_dp, m_en, p_en;
    logic         m_busy;
    int           fd_cnt;
    int           lit_cnt;

    function automatic bit lz_dark(int s);
`ifdef SEG_LZ_BLANK_EN
        if (s == 0) return 1'b0;
        for (int j = s; j < N; j++) begin
            if (m_dig[j*4 +: 4] != 4'h0 || m_dp[j]) return 1'b0;
        end
        return 1'b1;
`else
        return (s < 0);
`endif
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_dig = '0; m_dp = '0; m_en = '0;
        p_dig = '0; p_dp = '0; p_en = '0; m_busy = 1'b0;
    endtask

    // One clock: predict the registered outputs, advance, compare
    task automatic step();
        int k, s, pwm;
        bit on, bnd;
        logic [N-1:0] e_an;
        logic [6:0]   e_c;
        logic         e_dpn;
        logic [3:0]   dv;
        k   = m_cyc;
        s   = (k / RD) % N;
        pwm = k % (1 << BW);
        on  = ((br == '1) || (pwm < int'(br))) && m_en[s] && !lz_dark(s);
        dv  = m_dig[s*4 +: 4];
        e_an  = on ? ~(N'(1) << s) : '1;
        e_c   = on ? ~seg_on[dv] : 7'h7F;
        e_dpn = on ? ~m_dp[s] : 1'b1;
        bnd = (k % FRAME) == FRAME - 1;
        if (bnd && ld) begin
            m_dig = dig; m_dp = dpi; m_en = en; m_busy = 1'b0;
        end else if (ld) begin
            p_dig = dig; p_dp = dpi; p_en = en; m_busy = 1'b1;
        end else if (bnd && m_busy) begin
            m_dig = p_dig; m_dp = p_dp; m_en = p_en; m_busy = 1'b0;
        end
        @(posedge ck);
        #1;
        m_cyc++;
        if (frame_done === 1'b1) fd_cnt++;
        if (an !== '1) lit_cnt++;
        checks++;
        if (an !== e_an) begin
            errors++; $display("FAIL an cyc=%0d got=%b exp=%b", k, an, e_an);
        end
        checks++;
        if (c !== e_c) begin
            errors++; $display("FAIL c cyc=%0d got=%h exp=%h", k, c, e_c);
        end
        checks++;
        if (dp_n !== e_dpn) begin
            errors++; $display("FAIL dp_n cyc=%0d got=%b exp=%b", k, dp_n, e_dpn);
        end
        checks++;
        if (frame_done !== bnd) begin
            errors++; $display("FAIL frame_done cyc=%0d got=%b exp=%b", k, frame_done, bnd);
        end
        checks++;
        if (busy !== m_busy) begin
            errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", k, busy, m_busy);
        end
    endtask

    task automatic do_load(input logic [4*N-1:0] d, input logic [N-1:0] p,
                           input logic [N-1:0] e);
        dig = d; dpi = p; en = e; ld = 1'b1;
        step();
        ld = 1'b0;
    endtask

    task automatic run_until_phase(input int ph);
        while ((m_cyc % FRAME) != ph) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge ck);
        #1;
        checks++;
        if (an !== 3'b111 || c !== 7'h7F || dp_n !== 1'b1 || busy !== 1'b0 ||
            frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got an=%b c=%h dp_n=%b busy=%b fd=%b exp 111/7f/1/0/0",
                     an, c, dp_n, busy, frame_done);
        end
        rst_n = 1'b1;
        model_reset();
        fd_cnt = 0;
        repeat (2 * FRAME) step();
        checks++;
        if (fd_cnt != 2) begin
            errors++; $display("FAIL reset_frame_count got=%0d exp=2", fd_cnt);
        end
    endtask

    task automatic test_load_basic();
        br = 2'd3;
        run_until_phase(2);
        do_load(12'h5A3, 3'b010, 3'b111);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL load_busy got=%b exp=1", busy);
        end
        repeat (2 * FRAME) step();
    endtask

    task automatic test_double_load();
        bit saw_one;
        run_until_phase(1);
        do_load(12'h111, 3'b000, 3'b111);
        step(); step();
        do_load(12'h222, 3'b000, 3'b111);
        saw_one = 1'b0;
        repeat (2 * FRAME) begin
            step();
            if (c === 7'h4F) saw_one = 1'b1;
        end
        checks++;
        if (saw_one) begin
            errors++; $display("FAIL double_load_last_wins got=ones_seen exp=none");
        end
    endtask

    task automatic test_load_at_boundary();
        bit saw_busy;
        run_until_phase(FRAME - 1);
        do_load(12'h7C9, 3'b100, 3'b111);
        saw_busy = (busy === 1'b1);
        repeat (FRAME + 2) begin
            step();
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        checks++;
        if (saw_busy) begin
            errors++; $display("FAIL boundary_load_busy got=1 exp=0");
        end
    endtask

    task automatic test_brightness();
        run_until_phase(0);
        br = 2'd1;
        lit_cnt = 0;
        repeat (2 * FRAME) step();
        checks++;
        if (lit_cnt != 2 * FRAME / 4) begin
            errors++; $display("FAIL bright1_duty got=%0d exp=%0d", lit_cnt, 2 * FRAME / 4);
        end
        br = 2'd0;
        lit_cnt = 0;
        repeat (2 * FRAME) step();
        checks++;
        if (lit_cnt != 0) begin
            errors++; $display("FAIL bright0_dark got=%0d exp=0", lit_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            dig = 12'($urandom);
            dpi = 3'($urandom);
            en  = 3'($urandom);
            if ($urandom_range(0, 15) == 0) br = 2'($urandom);
            ld = ($urandom_range(0, 11) == 0);
            step();
            ld = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        br = 2'd3;
        do_load(12'h321, 3'b111, 3'b111);
        repeat (FRAME) step();
        run_until_phase(RD + 1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 3'b111 || c !== 7'h7F || dp_n !== 1'b1 || busy !== 1'b0 ||
            frame_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got an=%b c=%h dp_n=%b busy=%b fd=%b exp 111/7f/1/0/0",
                     an, c, dp_n, busy, frame_done);
        end
        @(posedge ck);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (FRAME) step();
        do_load(12'h654, 3'b001, 3'b111);
        repeat (2 * FRAME) step();
    endtask

`ifdef SEG_LZ_BLANK_EN
    task automatic test_lz();
        br = 2'd3;
        do_load(12'h00F, 3'b000, 3'b111);
        repeat (2 * FRAME) step();
        do_load(12'h00F, 3'b010, 3'b111);
        repeat (2 * FRAME) step();
    endtask
`endif

    initial begin
        rst_n = 1'b0; ld = 1'b0; dig = '0; dpi = '0; en = '0; br = '0;
        fd_cnt = 0; lit_cnt = 0;
        model_reset();
        test_reset();
        test_load_basic();
        test_double_load();
        test_load_at_boundary();
        test_brightness();
        test_random();
        test_reset_mid();
`ifdef SEG_LZ_BLANK_EN
        test_lz();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
